// File: rtl/uart_boot_loader.sv
// Serial boot loader: receives 8N1 bytes, parses sync/load/go frames, writes
// little-endian 32-bit words to RAM and holds the CPU in reset until 'G'.
module uart_boot_loader #(
    parameter int unsigned CLKS_PER_BIT = 417,
    parameter int unsigned ADDR_WIDTH   = 14
) (
    input  logic                  clk_48mhz,
    input  logic                  reset,
    input  logic                  rx_in,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    output logic                  ram_we,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  load_ok,
    output logic                  load_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_GO    = 8'h47;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [3:0] {
        F_WAIT_SYNC,
        F_CMD,
        F_ADDR0,
        F_ADDR1,
        F_ADDR2,
        F_ADDR3,
        F_CNT0,
        F_CNT1,
        F_DATA,
        F_CSUM
    } frame_state_t;

    rx_state_t    rx_state, rx_next;
    frame_state_t frame_state, frame_next;

    logic             rx_s1, rx_s2, rx_d;
    logic             rx_fall_c;
    logic             rx_tick_c;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic             frame_err;

    logic [23:0]           addr_buf;
    logic [31:0]           full_addr_c;
    logic [ADDR_WIDTH-1:0] word_ptr;
    logic [15:0]           word_cnt;
    logic [1:0]            byte_idx;
    logic [31:0]           wbuf;
    logic [7:0]            csum;
    logic                  unused_addr_bits;

    // Two-flop synchronizer plus one delay flop for falling-edge detection
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx_in;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign rx_fall_c = rx_d & ~rx_s2;

    always_ff @(posedge clk_48mhz) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next   = rx_state;
        rx_tick_c = (rx_state == RX_START) ? (clk_cnt == CNT_W'(HALF - 1))
                                           : (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
        case (rx_state)
            RX_IDLE:  if (rx_fall_c) rx_next = RX_START;
            RX_START: if (rx_tick_c) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick_c && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick_c) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Bit timing, shift register and byte/framing-error pulses
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            clk_cnt    <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (rx_state == RX_IDLE || rx_tick_c) clk_cnt <= '0;
            else                                  clk_cnt <= clk_cnt + CNT_W'(1);
            if (rx_state == RX_START) bit_idx <= '0;
            if (rx_state == RX_DATA && rx_tick_c) begin
                rx_byte <= {rx_s2, rx_byte[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (rx_state == RX_STOP && rx_tick_c) begin
                byte_valid <= rx_s2;
                frame_err  <= ~rx_s2;
            end
        end
    end

    assign full_addr_c      = {rx_byte, addr_buf};
    assign unused_addr_bits = ^{full_addr_c[1:0], full_addr_c[31:ADDR_WIDTH+2]};

    always_ff @(posedge clk_48mhz) begin
        if (reset) frame_state <= F_WAIT_SYNC;
        else       frame_state <= frame_next;
    end

    always_comb begin
        frame_next = frame_state;
        if (frame_err) begin
            frame_next = F_WAIT_SYNC;
        end else if (byte_valid) begin
            case (frame_state)
                F_WAIT_SYNC: if (rx_byte == SYNC_BYTE) frame_next = F_CMD;
                F_CMD:       frame_next = (rx_byte == CMD_LOAD) ? F_ADDR0 : F_WAIT_SYNC;
                F_ADDR0:     frame_next = F_ADDR1;
                F_ADDR1:     frame_next = F_ADDR2;
                F_ADDR2:     frame_next = F_ADDR3;
                F_ADDR3:     frame_next = F_CNT0;
                F_CNT0:      frame_next = F_CNT1;
                F_CNT1:      frame_next = ({rx_byte, word_cnt[7:0]} == 16'd0) ? F_CSUM : F_DATA;
                F_DATA:      if (byte_idx == 2'd3 && word_cnt == 16'd1) frame_next = F_CSUM;
                F_CSUM:      frame_next = F_WAIT_SYNC;
                default:     frame_next = F_WAIT_SYNC;
            endcase
        end
    end

    // Frame datapath: address/count capture, word assembly, RAM write, status
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            cpu_hold  <= 1'b1;
            busy      <= 1'b0;
            load_ok   <= 1'b0;
            load_err  <= 1'b0;
            addr_buf  <= '0;
            word_ptr  <= '0;
            word_cnt  <= '0;
            byte_idx  <= '0;
            wbuf      <= '0;
            csum      <= '0;
        end else begin
            ram_we <= 1'b0;
            busy   <= (frame_next != F_WAIT_SYNC);
            if (frame_err) begin
                load_err <= 1'b1;
            end else if (byte_valid) begin
                case (frame_state)
                    F_CMD: begin
                        if (rx_byte == CMD_LOAD) begin
                            load_ok  <= 1'b0;
                            load_err <= 1'b0;
                            csum     <= '0;
                            byte_idx <= '0;
                            cpu_hold <= 1'b1;
                        end else if (rx_byte == CMD_GO) begin
                            cpu_hold <= 1'b0;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                    F_ADDR0: addr_buf[7:0]   <= rx_byte;
                    F_ADDR1: addr_buf[15:8]  <= rx_byte;
                    F_ADDR2: addr_buf[23:16] <= rx_byte;
                    F_ADDR3: word_ptr        <= full_addr_c[ADDR_WIDTH+1:2];
                    F_CNT0:  word_cnt[7:0]   <= rx_byte;
                    F_CNT1:  word_cnt[15:8]  <= rx_byte;
                    F_DATA: begin
                        wbuf[{byte_idx, 3'b000} +: 8] <= rx_byte;
                        csum     <= csum + rx_byte;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            ram_we    <= 1'b1;
                            ram_addr  <= word_ptr;
                            ram_wdata <= {rx_byte, wbuf[23:0]};
                            word_ptr  <= word_ptr + ADDR_WIDTH'(1);
                            word_cnt  <= word_cnt - 16'd1;
                        end
                    end
                    F_CSUM: begin
                        if (rx_byte == csum) load_ok  <= 1'b1;
                        else                 load_err <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Randomized bench for uart_boot_loader: drives serial frames and compares RAM
// writes and status flags against a frame-level model of the load protocol.
module tb_uart_boot_loader;

    localparam int unsigned CPB = 16;
    localparam int unsigned AW  = 14;

    logic          clk_48mhz = 1'b0;
    logic          reset;
    logic          rx_in;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          ram_we;
    logic          cpu_hold;
    logic          busy;
    logic          load_ok;
    logic          load_err;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] obs_addr[$];
    logic [31:0]   obs_data[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    logic [31:0]   wbuf[8];
    logic          exp_ok, exp_err, exp_hold;

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clk_48mhz(clk_48mhz),
        .reset    (reset),
        .rx_in    (rx_in),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_we   (ram_we),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .load_ok  (load_ok),
        .load_err (load_err)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    always @(negedge clk_48mhz) begin
        if (ram_we) begin
            obs_addr.push_back(ram_addr);
            obs_data.push_back(ram_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk_48mhz);
        reset = 1'b0;
        exp_ok   = 1'b0;
        exp_err  = 1'b0;
        exp_hold = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk_48mhz);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (CPB) @(negedge clk_48mhz);
        end
        rx_in = stop;
        repeat (CPB) @(negedge clk_48mhz);
    endtask

    task automatic idle(input int unsigned cycles);
        rx_in = 1'b1;
        repeat (cycles) @(negedge clk_48mhz);
    endtask

    task automatic check_status(input string tag);
        check({tag, ".load_ok"},  64'(load_ok),  64'(exp_ok));
        check({tag, ".load_err"}, 64'(load_err), 64'(exp_err));
        check({tag, ".cpu_hold"}, 64'(cpu_hold), 64'(exp_hold));
        check({tag, ".busy"},     64'(busy),     64'd0);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, ".nwrites"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
        n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.addr%0d", tag, i), 64'(obs_addr[i]), 64'(exp_addr[i]));
            check($sformatf("%s.data%0d", tag, i), 64'(obs_data[i]), 64'(exp_data[i]));
        end
        obs_addr.delete(); obs_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    // Full load frame from wbuf[0..n-1]; model predicts writes and flags
    task automatic send_load(input logic [31:0] addr, input int n, input bit bad_csum);
        logic [7:0]  sum;
        logic [15:0] cnt;
        sum = 8'h00;
        cnt = 16'(n);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h4C, 1'b1);
        for (int k = 0; k < 4; k++) send_byte(addr[8*k +: 8], 1'b1);
        send_byte(cnt[7:0], 1'b1);
        send_byte(cnt[15:8], 1'b1);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(AW'((addr >> 2) + 32'(i)));
            exp_data.push_back(wbuf[i]);
            for (int k = 0; k < 4; k++) begin
                send_byte(wbuf[i][8*k +: 8], 1'b1);
                sum = sum + wbuf[i][8*k +: 8];
            end
        end
        send_byte(bad_csum ? sum + 8'h01 : sum, 1'b1);
        exp_hold = 1'b1;
        exp_ok   = !bad_csum;
        exp_err  = bad_csum;
        idle(4);
    endtask

    task automatic send_go(input string tag);
        send_byte(8'hA5, 1'b1);
        check({tag, ".busy_after_sync"}, 64'(busy), 64'd1);
        send_byte(8'h47, 1'b1);
        exp_hold = 1'b0;
        idle(4);
        check_status(tag);
    endtask

    initial begin
        do_reset();
        check("reset.cpu_hold", 64'(cpu_hold), 64'd1);
        check("reset.busy",     64'(busy),     64'd0);
        check("reset.ram_we",   64'(ram_we),   64'd0);
        check("reset.load_ok",  64'(load_ok),  64'd0);
        check("reset.load_err", 64'(load_err), 64'd0);
        idle(10000);
        compare_writes("idle");
        check_status("idle");

        wbuf[0] = 32'h44332211;
        wbuf[1] = 32'hDDCCBBAA;
        send_load(32'h0000_0008, 2, 1'b0);
        compare_writes("load2");
        check_status("load2");

        send_load(32'h0000_0008, 2, 1'b1);
        compare_writes("bad_csum");
        check_status("bad_csum");
        send_go("go");

        wbuf[0] = 32'h0BAD_F00D;
        wbuf[1] = 32'h1234_5678;
        send_load(32'h0000_FFFC, 2, 1'b0);
        compare_writes("wrap");
        check_status("wrap");

        // Framing error in the second address byte
        send_byte(8'hA5, 1'b1);
        send_byte(8'h4C, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h12, 1'b0);
        idle(2 * CPB);
        exp_ok  = 1'b0;
        exp_err = 1'b1;
        check_status("framing");
        wbuf[0] = 32'hCAFE_0147;
        send_load(32'h0000_0100, 1, 1'b0);
        compare_writes("after_framing");
        check_status("after_framing");

        // One-cycle low glitch produces nothing
        rx_in = 1'b0;
        @(negedge clk_48mhz);
        idle(3 * CPB);
        compare_writes("glitch");
        check_status("glitch");

        send_byte(8'hA5, 1'b1);
        send_byte(8'h55, 1'b1);
        exp_err = 1'b1;
        idle(4);
        check_status("bad_cmd");
        send_go("go2");

        // Reset during the third data byte of the first word
        send_byte(8'hA5, 1'b1);
        send_byte(8'h4C, 1'b1);
        send_byte(8'h40, 1'b1);
        for (int k = 0; k < 3; k++) send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        rx_in = 1'b0;
        repeat (3 * CPB) @(negedge clk_48mhz);
        do_reset();
        idle(2 * CPB);
        compare_writes("mid_reset");
        check_status("mid_reset");
        wbuf[0] = 32'hFEED_BEEF;
        wbuf[1] = 32'h0000_0047;
        send_load(32'h0000_0040, 2, 1'b0);
        compare_writes("after_reset");
        check_status("after_reset");

        for (int t = 0; t < 8; t++) begin
            int   n;
            bit   bad;
            n   = int'($urandom_range(0, 3));
            bad = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < n; i++) wbuf[i] = $urandom;
            send_load($urandom, n, bad);
            compare_writes($sformatf("rand%0d", t));
            check_status($sformatf("rand%0d", t));
            if ($urandom_range(0, 1) == 1) send_go($sformatf("rand_go%0d", t));
            idle($urandom_range(0, 2 * CPB));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
